// File: rtl/dram_controller.sv
// dram_controller: page-less DRAM controller for a 32-bit CPU bus with CAS-before-RAS refresh.
// Every output is registered from the next state, so strobes line up with the state register.
module dram_controller #(
    parameter int REFRESH_PERIOD   = 375,
    parameter int PRECHARGE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_DRAM_n,
    input  logic       AS_n,
    input  logic       RW,
    input  logic [1:0] SIZ,
    input  logic [1:0] A,
    output logic       RAS_n,
    output logic [3:0] CAS_n,
    output logic       WE_n,
    output logic       ADDR_SEL,
    output logic       DSACK0_n,
    output logic       DSACK1_n,
    output logic       REF_BUSY
);
    localparam int RCW = $clog2(REFRESH_PERIOD);
    localparam int CW  = $clog2(PRECHARGE_CYCLES + 2) + 1;
    localparam logic [RCW-1:0] REF_TC   = RCW'(REFRESH_PERIOD - 1);
    localparam logic [CW-1:0]  PRE_LAST = CW'(PRECHARGE_CYCLES - 1);
    localparam logic [CW-1:0]  RAS_LAST = CW'(1);

    typedef enum logic [2:0] {IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, REF_HOLD} state_t;

    state_t         state_q, state_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pend_q, pend_d;
    logic           ras_n_q, ras_n_d;
    logic [3:0]     cas_n_q, cas_n_d;
    logic           we_n_q, we_n_d;
    logic           addr_sel_q, addr_sel_d;
    logic           dsack_n_q, dsack_n_d;
    logic           ref_busy_q, ref_busy_d;
    logic           tc;
    logic [2:0]     n, hi;
    logic [3:0]     lanes;

    always_comb begin
        tc      = rcnt_q == REF_TC;
        rcnt_d  = tc ? '0 : rcnt_q + 1'b1;
        pend_d  = pend_q | tc;
        state_d = state_q;
        n       = (SIZ == 2'b00) ? 3'd4 : {1'b0, SIZ};
        hi      = {1'b0, A} + n - 3'd1;
        lanes   = '0;
        for (int i = 0; i < 4; i++) lanes[i] = (3'(i) >= {1'b0, A}) && (3'(i) <= hi);
        // a terminal count on this very edge already outranks a new access
        case (state_q)
            IDLE:     state_d = (pend_q || tc) ? REF_CAS : (!CS_DRAM_n && !AS_n) ? ROW : IDLE;
            ROW:      state_d = AS_n ? PRE : COL;
            COL:      state_d = AS_n ? PRE : ACK;
            ACK:      state_d = AS_n ? PRE : ACK;
            PRE:      state_d = (cnt_q == PRE_LAST) ? IDLE : PRE;
            REF_CAS:  state_d = REF_RAS;
            REF_RAS:  state_d = (cnt_q == RAS_LAST) ? REF_HOLD : REF_RAS;
            REF_HOLD: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = IDLE;
                    pend_d  = tc;
                end
            end
            default:  state_d = IDLE;
        endcase
        cnt_d      = (state_d != state_q) ? '0 : cnt_q + 1'b1;
        ras_n_d    = !(state_d inside {ROW, COL, ACK, REF_RAS});
        cas_n_d    = (state_d == COL) ? (RW ? 4'b0000 : ~lanes) :
                     (state_d == ACK) ? cas_n_q :
                     (state_d inside {REF_CAS, REF_RAS}) ? 4'b0000 : 4'b1111;
        we_n_d     = (state_d == COL) ? RW : (state_d == ACK) ? we_n_q : 1'b1;
        addr_sel_d = state_d inside {COL, ACK};
        dsack_n_d  = state_d != ACK;
        ref_busy_d = state_d inside {REF_CAS, REF_RAS, REF_HOLD};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rcnt_q     <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 4'b1111;
            we_n_q     <= 1'b1;
            addr_sel_q <= 1'b0;
            dsack_n_q  <= 1'b1;
            ref_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            addr_sel_q <= addr_sel_d;
            dsack_n_q  <= dsack_n_d;
            ref_busy_q <= ref_busy_d;
        end
    end

    assign RAS_n    = ras_n_q;
    assign CAS_n    = cas_n_q;
    assign WE_n     = we_n_q;
    assign ADDR_SEL = addr_sel_q;
    assign DSACK0_n = dsack_n_q;
    assign DSACK1_n = dsack_n_q;
    assign REF_BUSY = ref_busy_q;
endmodule

// File: tb/tb_dram_controller.sv
// tb_dram_controller: random and directed bus cycles checked against lane arithmetic and refresh timing.
module tb_dram_controller;
    localparam int RP = 375;
    localparam int PC = 2;
    localparam logic [9:0] IDLE_OUT = {1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic       CLK = 1'b0, RST = 1'b1, CS_DRAM_n = 1'b1, AS_n = 1'b1, RW = 1'b1;
    logic [1:0] SIZ = 2'b00, A = 2'b00;
    logic       RAS_n, WE_n, ADDR_SEL, DSACK0_n, DSACK1_n, REF_BUSY;
    logic [3:0] CAS_n;
    logic [9:0] outs;
    int total = 0, bad = 0, viol = 0, cyc = 0, rb_len = 0;
    int ref_starts[$];

    dram_controller #(.REFRESH_PERIOD(RP), .PRECHARGE_CYCLES(PC)) dut (
        .CLK(CLK), .RST(RST), .CS_DRAM_n(CS_DRAM_n), .AS_n(AS_n), .RW(RW), .SIZ(SIZ), .A(A),
        .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n), .ADDR_SEL(ADDR_SEL),
        .DSACK0_n(DSACK0_n), .DSACK1_n(DSACK1_n), .REF_BUSY(REF_BUSY)
    );

    always #5 CLK = ~CLK;
    assign outs = {RAS_n, CAS_n, WE_n, ADDR_SEL, DSACK0_n, DSACK1_n, REF_BUSY};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc = RST ? 0 : cyc + 1;

    // refresh bookkeeping and always-true bus rules, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST) begin
            rb_len = 0;
            ref_starts.delete();
        end else begin
            if (REF_BUSY) begin
                if (rb_len == 0) begin
                    ref_starts.push_back(cyc);
                    if (CAS_n !== 4'h0 || RAS_n !== 1'b1) viol++;
                end
                rb_len++;
            end else if (rb_len != 0) begin
                check("ref_len", rb_len, 3 + PC);
                rb_len = 0;
            end
            if (!DSACK0_n && REF_BUSY) viol++;
            if (DSACK0_n !== DSACK1_n) viol++;
            if (!WE_n && (RAS_n || REF_BUSY)) viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [3:0] exp_cas(input logic rw, input logic [1:0] siz, input logic [1:0] a);
        int n;
        logic [3:0] m;
        n = (siz == 2'b00) ? 4 : int'(siz);
        m = 4'hF;
        if (rw) return 4'h0;
        for (int i = 0; i < 4; i++) if (i >= int'(a) && i < int'(a) + n) m[i] = 1'b0;
        return m;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_row(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!RAS_n && !REF_BUSY) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic finish_pre(input string tag);
        int pbad;
        pbad = 0;
        for (int i = 1; i < PC; i++) begin
            step();
            if (RAS_n !== 1'b1 || DSACK0_n !== 1'b1) pbad++;
        end
        check(tag, pbad, 0);
    endtask

    // abort_at: 0 = full cycle, 1 = AS_n rises in ROW, 2 = AS_n rises in COL
    task automatic access(input logic rw, input logic [1:0] siz, input logic [1:0] a,
                          input int hold, input int abort_at, output int row_cyc);
        logic [3:0] ec;
        bit ok;
        int hbad;
        ec = exp_cas(rw, siz, a);
        CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = rw; SIZ = siz; A = a;
        wait_row(ok);
        row_cyc = cyc;
        check("row_seen", ok, 1);
        if (!ok) begin
            CS_DRAM_n = 1'b1; AS_n = 1'b1;
            return;
        end
        check("row", {RAS_n, ADDR_SEL, CAS_n, WE_n, DSACK0_n}, {1'b0, 1'b0, 4'hF, 1'b1, 1'b1});
        if (abort_at != 1) begin
            step();
            check("col", {RAS_n, ADDR_SEL, CAS_n, WE_n, DSACK0_n}, {1'b0, 1'b1, ec, rw, 1'b1});
        end
        if (abort_at != 0) begin
            CS_DRAM_n = 1'b1; AS_n = 1'b1;
            step();
            check("abort_release", outs, IDLE_OUT);
            finish_pre("abort_pre");
            return;
        end
        step();
        check("ack", {RAS_n, CAS_n, WE_n, DSACK0_n, DSACK1_n}, {1'b0, ec, rw, 1'b0, 1'b0});
        hbad = 0;
        for (int i = 1; i < hold; i++) begin
            step();
            if ({RAS_n, CAS_n, WE_n, DSACK0_n} !== {1'b0, ec, rw, 1'b0}) hbad++;
        end
        check("ack_hold", hbad, 0);
        CS_DRAM_n = 1'b1; AS_n = 1'b1;
        step();
        check("release", outs, IDLE_OUT);
        finish_pre("pre");
    endtask

    initial begin
        int rc, tcyc, cnt, gap, ab;
        bit ok;
        logic rw;
        logic [1:0] siz, a;
        repeat (3) step();
        check("reset_outputs", outs, IDLE_OUT);
        RST = 1'b0;

        // idle: three CBR refreshes at P, 2P, 3P
        for (int k = 1; k <= 3; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 2 * RP && !ok; i++) begin
                step();
                ok = REF_BUSY;
            end
            check("ref_seen", ok, 1);
            check("ref_cycle", cyc, k * RP);
            check("cbr_cas", {RAS_n, CAS_n, DSACK0_n}, {1'b1, 4'h0, 1'b1});
            step();
            check("cbr_ras1", {RAS_n, CAS_n, REF_BUSY}, {1'b0, 4'h0, 1'b1});
            step();
            check("cbr_ras2", {RAS_n, CAS_n, REF_BUSY}, {1'b0, 4'h0, 1'b1});
            for (int i = 0; i < PC; i++) begin
                step();
                check("cbr_hold", {RAS_n, CAS_n, REF_BUSY}, {1'b1, 4'hF, 1'b1});
            end
            step();
            check("ref_end", REF_BUSY, 0);
        end
        check("ref_count_idle", ref_starts.size(), 3);

        access(1'b1, 2'b00, 2'd0, 2, 0, rc);
        access(1'b0, 2'b01, 2'd2, 1, 0, rc);
        access(1'b0, 2'b11, 2'd1, 3, 0, rc);
        access(1'b0, 2'b10, 2'd3, 1, 0, rc);
        access(1'b0, 2'b00, 2'd0, 1, 1, rc);
        access(1'b0, 2'b10, 2'd1, 1, 2, rc);

        CS_DRAM_n = 1'b1; AS_n = 1'b0;
        cnt = 0;
        repeat (6) begin
            step();
            if (!RAS_n && !REF_BUSY) cnt++;
        end
        check("unselected", cnt, 0);
        AS_n = 1'b1;

        // request presented on the terminal-count edge
        ok = 1'b0;
        for (int i = 0; i < 2 * RP && !ok; i++) begin
            step();
            ok = (cyc % RP == RP - 1) && !REF_BUSY && RAS_n;
        end
        check("coll_align", ok, 1);
        tcyc = cyc + 1;
        access(1'b0, 2'b01, 2'd1, 2, 0, rc);
        check("coll_ref_first", ref_starts[$], tcyc);
        check("coll_row_after", rc, tcyc + 4 + PC);

        for (int t = 0; t < 40; t++) begin
            rw  = 1'($urandom_range(0, 1));
            siz = 2'($urandom_range(0, 3));
            a   = 2'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            access(rw, siz, a, int'($urandom_range(1, 4)), ab, rc);
            gap = int'($urandom_range(0, 3));
            repeat (gap) step();
        end

        CS_DRAM_n = 1'b0; AS_n = 1'b0; RW = 1'b1; SIZ = 2'b00; A = 2'd0;
        wait_row(ok);
        check("rst_row_seen", ok, 1);
        step();
        step();
        check("rst_in_ack", DSACK0_n, 0);
        RST = 1'b1; AS_n = 1'b1; CS_DRAM_n = 1'b1;
        step();
        check("rst_mid_ack", outs, IDLE_OUT);
        RST = 1'b0;
        cnt = 0;
        repeat (6) begin
            step();
            if (!DSACK0_n || !DSACK1_n) cnt++;
        end
        check("rst_no_dsack", cnt, 0);

        for (int t = 0; t < 10; t++) begin
            rw  = 1'($urandom_range(0, 1));
            siz = 2'($urandom_range(0, 3));
            a   = 2'($urandom_range(0, 3));
            access(rw, siz, a, int'($urandom_range(1, 3)), 0, rc);
        end

        ok = 1'b0;
        for (int i = 0; i < 4 * RP && !ok; i++) begin
            step();
            ok = (cyc > RP) && (cyc % RP == RP / 2);
        end
        check("final_align", ok, 1);
        check("ref_count_total", ref_starts.size(), cyc / RP);
        check("invariants", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
